vga_pixel_arbiter: RTL and testbench
====================================

// Module: vga_pixel_arbiter
// PURPOSE
//  Owns the single VGA-adapter pixel-write port and shares it between the HPS PIO pixel bundle
//  and the fpga_portion pixel stream. Adds a built-in clear-screen engine.
//  Sits between the HPS system / fpga_portion and the VGA adapter; all outputs registered.
// PARAMETERS
//  X_W    9    width of x coordinate
//  Y_W    8    width of y coordinate
//  C_W    3    colour width
//  W_HI   320  width when mode=1;  H_HI 240  height when mode=1
//  W_LO   160  width when mode=0;  H_LO 120  height when mode=0
// PORTS
//  CLOCK_50      in   1      clock; all logic on rising edge
//  reset         in   1      synchronous, active-high reset
//  hps_bundle    in   1+X_W+Y_W+C_W+1   {mode,x,y,colour,writeEn} level PIO word from HPS
//  fpga_x        in   X_W    fpga_portion pixel x
//  fpga_y        in   Y_W    fpga_portion pixel y
//  fpga_colour   in   C_W    fpga_portion pixel colour
//  fpga_valid    in   1      fpga pixel offered
//  fpga_ready    out  1      fpga pixel accepted when valid&ready
//  clear_req     in   1      start clear-screen (level sampled per cycle)
//  clear_colour  in   C_W    fill colour, latched on clear start
//  clear_busy    out  1      clear engine owns port
//  hps_overrun   out  1      sticky: HPS edge lost because holding reg full
//  vga_x/vga_y/vga_colour out X_W/Y_W/C_W  pixel to adapter
//  vga_plot      out  1      one-cycle write strobe to adapter
//  vga_mode      out  1      registered resolution mode (hps_bundle mode bit, 1-cycle delay)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, holding empty, last_grant=FPGA (HPS wins first tie).
//  HPS path: writeEn registered (we_q); edge = writeEn & ~we_q. On edge, {x,y,colour}
//   load 1-entry holding reg next cycle (hps_pend=1). Held-high writeEn = one request only.
//   Edge while holding full and not being granted that cycle -> request dropped, hps_overrun=1
//   (cleared only by reset). Edge in same cycle as holding grant -> reloads, no overrun.
//  FSM IDLE (serve requesters):
//   fpga_ready = !hps_pend | (last_grant==HPS); independent of fpga_valid.
//   Grant HPS if hps_pend & (!fpga_valid | last_grant==FPGA); else FPGA if valid&ready.
//   Granted pixel drives vga_x/y/colour and vga_plot=1 on the next cycle; last_grant updated.
//   Both pending every cycle -> strict alternation, one pixel per cycle.
//   Out-of-range pixel (x>=W or y>=H for current vga_mode) is consumed but vga_plot stays 0.
//   clear_req=1 in IDLE -> CLEAR next cycle; clear has priority over pending requests
//   that cycle; latch clear_colour and mode; counters x=0,y=0.
//  FSM CLEAR: fpga_ready=0, holding not granted (still captures one HPS edge).
//   One pixel per cycle, x inner, y outer; plot (x,y,clear_colour).
//   After pixel (W-1,H-1) -> IDLE; total W*H plots (19200 mode0, 76800 mode1).
//   clear_busy=1 for exactly the W*H cycles in CLEAR; clear_req ignored while busy.
//  vga_plot=0 on any cycle with no grant/clear pixel; vga_x/y/colour hold last values.
//  Reset mid-clear or mid-transfer: aborts at next edge, outputs to reset values, no plot.
//  Mode change mid-clear ignored by engine; takes effect for range checks after return.
// TESTING
//  T1 reset asserted 3 cycles -> vga_plot,clear_busy,hps_overrun,fpga_ready... all 0 then ready=1.
//  T2 HPS writeEn 0->1 with x=10,y=20,c=5, held 10 cycles -> exactly one vga_plot, 2 cycles after edge.
//  T3 fpga_valid high 4 cycles, pixels (0,0)..(3,0), no HPS -> 4 back-to-back plots, 1-cycle latency.
//  T4 HPS pending + fpga_valid continuous -> grant order HPS,FPGA,HPS,FPGA; fpga_ready toggles.
//  T5 mode=0, clear_req pulse, colour=3 -> 19200 plots, last (159,119); busy 19200 cycles;
//     HPS edge during clear plotted right after; second edge during clear -> hps_overrun=1.
//  T6 mode=0, fpga pixel x=200,y=5 -> accepted (ready=1), no vga_plot; reset mid-clear -> busy=0 next cycle.

Source files
------------

// File: rtl/vga_pixel_arbiter.sv
// rtl/vga_pixel_arbiter.sv - shares the VGA adapter pixel port between HPS PIO, fpga stream and a clear engine
// HPS writes arrive as rising edges of a level PIO bit and wait in a one-entry holding register.
module vga_pixel_arbiter #(
  parameter int X_W  = 9,
  parameter int Y_W  = 8,
  parameter int C_W  = 3,
  parameter int W_HI = 320,
  parameter int H_HI = 240,
  parameter int W_LO = 160,
  parameter int H_LO = 120
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic [X_W+Y_W+C_W+1:0] hps_bundle,
  input  logic [X_W-1:0]         fpga_x,
  input  logic [Y_W-1:0]         fpga_y,
  input  logic [C_W-1:0]         fpga_colour,
  input  logic                   fpga_valid,
  output logic                   fpga_ready,
  input  logic                   clear_req,
  input  logic [C_W-1:0]         clear_colour,
  output logic                   clear_busy,
  output logic                   hps_overrun,
  output logic [X_W-1:0]         vga_x,
  output logic [Y_W-1:0]         vga_y,
  output logic [C_W-1:0]         vga_colour,
  output logic                   vga_plot,
  output logic                   vga_mode
);

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t         r_state, w_state_nxt;
  logic           r_we_q, r_hps_pend, r_last_hps, r_overrun, r_fpga_ready;
  logic [X_W-1:0] r_hold_x, r_vga_x, r_cx;
  logic [Y_W-1:0] r_hold_y, r_vga_y, r_cy;
  logic [C_W-1:0] r_hold_c, r_vga_c, r_clr_c;
  logic           r_plot, r_mode, r_clr_mode;

  logic           w_we, w_mode, w_edge;
  logic [X_W-1:0] w_hx, w_px, w_cur_w, w_clr_xmax;
  logic [Y_W-1:0] w_hy, w_py, w_cur_h, w_clr_ymax;
  logic [C_W-1:0] w_hc, w_pc;
  logic           w_grant_hps, w_grant_fpga, w_in_range, w_clr_last;
  logic           w_pend_nxt, w_last_nxt, w_load, w_drop;

  assign w_we   = hps_bundle[0];
  assign w_hc   = hps_bundle[C_W:1];
  assign w_hy   = hps_bundle[C_W+Y_W:C_W+1];
  assign w_hx   = hps_bundle[C_W+Y_W+X_W:C_W+Y_W+1];
  assign w_mode = hps_bundle[X_W+Y_W+C_W+1];
  assign w_edge = w_we & ~r_we_q;

  // Range checks follow the live mode; the clear engine uses the mode latched at start.
  assign w_cur_w    = r_mode ? X_W'(W_HI) : X_W'(W_LO);
  assign w_cur_h    = r_mode ? Y_W'(H_HI) : Y_W'(H_LO);
  assign w_clr_xmax = r_clr_mode ? X_W'(W_HI - 1) : X_W'(W_LO - 1);
  assign w_clr_ymax = r_clr_mode ? Y_W'(H_HI - 1) : Y_W'(H_LO - 1);
  assign w_clr_last = (r_cx == w_clr_xmax) && (r_cy == w_clr_ymax);

  assign w_px       = w_grant_hps ? r_hold_x : fpga_x;
  assign w_py       = w_grant_hps ? r_hold_y : fpga_y;
  assign w_pc       = w_grant_hps ? r_hold_c : fpga_colour;
  assign w_in_range = (w_px < w_cur_w) && (w_py < w_cur_h);

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_hps  = 1'b0;
    w_grant_fpga = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (clear_req) begin
          w_state_nxt = S_CLEAR;
        end else begin
          w_grant_hps  = r_hps_pend & (~fpga_valid | ~r_last_hps);
          w_grant_fpga = ~w_grant_hps & fpga_valid & fpga_ready;
        end
      end
      S_CLEAR: begin
        if (w_clr_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A new edge may refill the holding register only if it is empty or being drained this cycle.
  always_comb begin
    w_pend_nxt = r_hps_pend & ~w_grant_hps;
    w_load     = 1'b0;
    w_drop     = 1'b0;
    if (w_edge) begin
      if (~r_hps_pend | w_grant_hps) begin
        w_load     = 1'b1;
        w_pend_nxt = 1'b1;
      end else begin
        w_drop = 1'b1;
      end
    end
    w_last_nxt = w_grant_hps ? 1'b1 : (w_grant_fpga ? 1'b0 : r_last_hps);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_we_q       <= 1'b0;
      r_hps_pend   <= 1'b0;
      r_last_hps   <= 1'b0;
      r_overrun    <= 1'b0;
      r_fpga_ready <= 1'b0;
      r_hold_x     <= '0;
      r_hold_y     <= '0;
      r_hold_c     <= '0;
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_c      <= '0;
      r_plot       <= 1'b0;
      r_mode       <= 1'b0;
      r_clr_mode   <= 1'b0;
      r_clr_c      <= '0;
      r_cx         <= '0;
      r_cy         <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_we_q       <= w_we;
      r_mode       <= w_mode;
      r_hps_pend   <= w_pend_nxt;
      r_last_hps   <= w_last_nxt;
      r_fpga_ready <= (w_state_nxt == S_IDLE) & (~w_pend_nxt | w_last_nxt);
      if (w_load) begin
        r_hold_x <= w_hx;
        r_hold_y <= w_hy;
        r_hold_c <= w_hc;
      end
      if (w_drop) r_overrun <= 1'b1;
      if (r_state == S_IDLE && clear_req) begin
        r_clr_c    <= clear_colour;
        r_clr_mode <= r_mode;
        r_cx       <= '0;
        r_cy       <= '0;
      end
      r_plot <= 1'b0;
      if (r_state == S_CLEAR) begin
        r_vga_x <= r_cx;
        r_vga_y <= r_cy;
        r_vga_c <= r_clr_c;
        r_plot  <= 1'b1;
        if (r_cx == w_clr_xmax) begin
          r_cx <= '0;
          r_cy <= r_cy + 1'b1;
        end else begin
          r_cx <= r_cx + 1'b1;
        end
      end else if ((w_grant_hps | w_grant_fpga) && w_in_range) begin
        r_vga_x <= w_px;
        r_vga_y <= w_py;
        r_vga_c <= w_pc;
        r_plot  <= 1'b1;
      end
    end
  end

  // Ready is withdrawn while a clear request is being taken so no fpga beat is lost.
  assign fpga_ready  = r_fpga_ready & ~clear_req;
  assign clear_busy  = (r_state == S_CLEAR);
  assign hps_overrun = r_overrun;
  assign vga_x       = r_vga_x;
  assign vga_y       = r_vga_y;
  assign vga_colour  = r_vga_c;
  assign vga_plot    = r_plot;
  assign vga_mode    = r_mode;

endmodule

// File: tb/tb_vga_pixel_arbiter.sv
// tb/tb_vga_pixel_arbiter.sv - vector table plus clear-screen and reset sequences for vga_pixel_arbiter
module tb_vga_pixel_arbiter;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        t_we, t_mode;
  logic [8:0]  t_hx;
  logic [7:0]  t_hy;
  logic [2:0]  t_hc;
  logic [21:0] hps_bundle;
  logic [8:0]  fpga_x;
  logic [7:0]  fpga_y;
  logic [2:0]  fpga_colour;
  logic        fpga_valid, fpga_ready;
  logic        clear_req, clear_busy, hps_overrun;
  logic [2:0]  clear_colour;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot, vga_mode;

  assign hps_bundle = {t_mode, t_hx, t_hy, t_hc, t_we};

  always #5 CLOCK_50 = ~CLOCK_50;

  vga_pixel_arbiter dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .hps_bundle   (hps_bundle),
    .fpga_x       (fpga_x),
    .fpga_y       (fpga_y),
    .fpga_colour  (fpga_colour),
    .fpga_valid   (fpga_valid),
    .fpga_ready   (fpga_ready),
    .clear_req    (clear_req),
    .clear_colour (clear_colour),
    .clear_busy   (clear_busy),
    .hps_overrun  (hps_overrun),
    .vga_x        (vga_x),
    .vga_y        (vga_y),
    .vga_colour   (vga_colour),
    .vga_plot     (vga_plot),
    .vga_mode     (vga_mode)
  );

  typedef struct {
    logic       rst, we, md, fv;
    logic [8:0] hx, fx;
    logic [7:0] hy, fy;
    logic [2:0] hc, fc;
    logic       e_rdy, e_plot;
    logic [8:0] ex;
    logic [7:0] ey;
    logic [2:0] ec;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input int rst, we, hx, hy, hc, fv, fx, fy, fc, md,
                     input int rdy, pl, ex, ey, ec);
    vec_t v;
    v.rst = 1'(rst);   v.we = 1'(we);    v.md = 1'(md);    v.fv = 1'(fv);
    v.hx  = 9'(hx);    v.hy = 8'(hy);    v.hc = 3'(hc);
    v.fx  = 9'(fx);    v.fy = 8'(fy);    v.fc = 3'(fc);
    v.e_rdy = 1'(rdy); v.e_plot = 1'(pl);
    v.ex  = 9'(ex);    v.ey = 8'(ey);    v.ec = 3'(ec);
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  int busy_cnt, clr_plots, bad_pix, hps_s, extra, ex, ey;
  int lx, ly, hpx, hpy, hpc;

  initial begin
    reset = 1'b1; t_we = 0; t_mode = 0; t_hx = 0; t_hy = 0; t_hc = 0;
    fpga_x = 0; fpga_y = 0; fpga_colour = 0; fpga_valid = 0;
    clear_req = 0; clear_colour = 0;

    // reset, then release
    add(1,0,0,0,0, 0,0,0,0, 0,  0,0,0,0,0);
    add(1,0,0,0,0, 0,0,0,0, 0,  0,0,0,0,0);
    add(0,0,0,0,0, 0,0,0,0, 0,  0,0,0,0,0);
    add(0,0,0,0,0, 0,0,0,0, 0,  1,0,0,0,0);
    // HPS writeEn held high: one plot two cycles after the edge
    add(0,1,10,20,5, 0,0,0,0, 0,  1,0,0,0,0);
    add(0,1,10,20,5, 0,0,0,0, 0,  0,1,10,20,5);
    for (int i = 0; i < 8; i++) add(0,1,10,20,5, 0,0,0,0, 0,  1,0,0,0,0);
    add(0,0,0,0,0, 0,0,0,0, 0,  1,0,0,0,0);
    // fpga stream back to back
    for (int i = 0; i < 4; i++) add(0,0,0,0,0, 1,i,0,i+1, 0,  1,1,i,0,i+1);
    add(0,0,0,0,0, 0,0,0,0, 0,  1,0,0,0,0);
    // HPS and fpga contending: alternation
    add(0,1,1,2,6, 0,0,0,0, 0,     1,0,0,0,0);
    add(0,0,0,0,0, 1,50,60,7, 0,   0,1,1,2,6);
    add(0,1,3,4,2, 1,50,60,7, 0,   1,1,50,60,7);
    add(0,0,0,0,0, 1,51,61,1, 0,   0,1,3,4,2);
    add(0,1,5,6,3, 1,51,61,1, 0,   1,1,51,61,1);
    add(0,0,0,0,0, 1,52,62,4, 0,   0,1,5,6,3);
    add(0,0,0,0,0, 1,52,62,4, 0,   1,1,52,62,4);
    add(0,1,7,8,1, 0,0,0,0, 0,     1,0,0,0,0);
    add(0,0,0,0,0, 0,0,0,0, 0,     0,1,7,8,1);
    add(0,1,9,9,2, 0,0,0,0, 0,     1,0,0,0,0);
    add(0,0,0,0,0, 1,60,70,5, 0,   1,1,60,70,5);
    add(0,0,0,0,0, 1,61,71,6, 0,   0,1,9,9,2);
    add(0,0,0,0,0, 1,61,71,6, 0,   1,1,61,71,6);
    add(0,0,0,0,0, 0,0,0,0, 0,     1,0,0,0,0);
    // edge in the same cycle as the holding grant reloads it
    add(0,1,11,12,3, 0,0,0,0, 0,   1,0,0,0,0);
    add(0,0,0,0,0, 0,0,0,0, 0,     0,1,11,12,3);
    add(0,1,13,14,4, 0,0,0,0, 0,   1,0,0,0,0);
    add(0,0,0,0,0, 1,70,80,7, 0,   1,1,70,80,7);
    add(0,1,15,16,5, 1,71,81,1, 0, 0,1,13,14,4);
    add(0,1,15,16,5, 1,71,81,1, 0, 1,1,71,81,1);
    add(0,0,0,0,0, 0,0,0,0, 0,     0,1,15,16,5);
    add(0,0,0,0,0, 0,0,0,0, 0,     1,0,0,0,0);
    // range checks in both modes
    add(0,0,0,0,0, 1,200,5,2, 0,   1,0,0,0,0);
    add(0,0,0,0,0, 1,159,119,3, 0, 1,1,159,119,3);
    add(0,0,0,0,0, 1,160,0,1, 0,   1,0,0,0,0);
    add(0,0,0,0,0, 0,0,0,0, 1,     1,0,0,0,0);
    add(0,0,0,0,0, 1,200,5,2, 1,   1,1,200,5,2);
    add(0,0,0,0,0, 1,319,239,4, 1, 1,1,319,239,4);
    add(0,0,0,0,0, 1,320,10,1, 1,  1,0,0,0,0);
    add(0,0,0,0,0, 1,5,240,1, 1,   1,0,0,0,0);
    add(0,0,0,0,0, 0,0,0,0, 0,     1,0,0,0,0);
    add(0,0,0,0,0, 0,0,0,0, 0,     1,0,0,0,0);

    tick();
    foreach (vq[k]) begin
      reset = vq[k].rst; t_we = vq[k].we; t_mode = vq[k].md;
      t_hx = vq[k].hx; t_hy = vq[k].hy; t_hc = vq[k].hc;
      fpga_valid = vq[k].fv; fpga_x = vq[k].fx; fpga_y = vq[k].fy; fpga_colour = vq[k].fc;
      #2;
      chk($sformatf("v%0d ready", k), int'(fpga_ready), int'(vq[k].e_rdy));
      tick();
      chk($sformatf("v%0d plot", k), int'(vga_plot), int'(vq[k].e_plot));
      chk($sformatf("v%0d busy", k), int'(clear_busy), 0);
      chk($sformatf("v%0d overrun", k), int'(hps_overrun), 0);
      if (vq[k].e_plot || vq[k].rst) begin
        chk($sformatf("v%0d x", k), int'(vga_x), int'(vq[k].ex));
        chk($sformatf("v%0d y", k), int'(vga_y), int'(vq[k].ey));
        chk($sformatf("v%0d colour", k), int'(vga_colour), int'(vq[k].ec));
      end
    end

    // clear screen in mode 0, with HPS traffic and mode glitch during the clear
    fpga_valid = 0; t_we = 0; t_mode = 0;
    clear_req = 1; clear_colour = 3;
    #2;
    chk("clear_start ready", int'(fpga_ready), 0);
    busy_cnt = 0; clr_plots = 0; bad_pix = 0; hps_s = -1; extra = 0;
    ex = 0; ey = 0; lx = -1; ly = -1; hpx = 0; hpy = 0; hpc = 0;
    @(posedge CLOCK_50);
    #1;
    for (int s = 0; s <= 19205; s++) begin
      if (s > 0) tick();
      if (clear_busy) busy_cnt++;
      if (vga_plot) begin
        if (clr_plots < 19200) begin
          if (int'(vga_x) != ex || int'(vga_y) != ey || vga_colour != 3'd3 || s != clr_plots + 1)
            bad_pix++;
          lx = int'(vga_x); ly = int'(vga_y);
          clr_plots++;
          if (ex == 159) begin ex = 0; ey++; end else ex++;
        end else if (hps_s < 0) begin
          hps_s = s; hpx = int'(vga_x); hpy = int'(vga_y); hpc = int'(vga_colour);
        end else begin
          extra++;
        end
      end
      if (s == 102) chk("overrun before second edge", int'(hps_overrun), 0);
      if (s == 250) chk("ready during clear", int'(fpga_ready), 0);
      case (s)
        2:   clear_colour = 7;
        5:   clear_req = 0;
        50:  t_mode = 1;
        60:  t_mode = 0;
        100: begin t_we = 1; t_hx = 33; t_hy = 44; t_hc = 6; end
        101: t_we = 0;
        102: begin t_we = 1; t_hx = 99; t_hy = 99; t_hc = 1; end
        103: t_we = 0;
        200: begin fpga_valid = 1; fpga_x = 1; fpga_y = 1; fpga_colour = 1; end
        300: fpga_valid = 0;
        default: ;
      endcase
    end
    chk("clear pixel sequence errors", bad_pix, 0);
    chk("clear plot count", clr_plots, 19200);
    chk("clear busy cycles", busy_cnt, 19200);
    chk("clear last x", lx, 159);
    chk("clear last y", ly, 119);
    chk("hps after clear cycle", hps_s, 19201);
    chk("hps after clear x", hpx, 33);
    chk("hps after clear y", hpy, 44);
    chk("hps after clear colour", hpc, 6);
    chk("extra plots after clear", extra, 0);
    chk("overrun sticky", int'(hps_overrun), 1);

    // reset in the middle of a clear
    clear_req = 1; clear_colour = 5;
    tick();
    chk("second clear busy", int'(clear_busy), 1);
    clear_req = 0;
    repeat (40) tick();
    chk("mid clear plotting", int'(vga_plot), 1);
    reset = 1;
    tick();
    chk("reset mid clear busy", int'(clear_busy), 0);
    chk("reset mid clear plot", int'(vga_plot), 0);
    chk("reset mid clear overrun", int'(hps_overrun), 0);
    chk("reset mid clear x", int'(vga_x), 0);
    chk("reset mid clear ready", int'(fpga_ready), 0);
    reset = 0;
    tick();
    chk("after reset ready", int'(fpga_ready), 1);
    chk("after reset busy", int'(clear_busy), 0);
    tick();
    chk("after reset plot", int'(vga_plot), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
